lockstep_retire_checker: RTL and testbench
==========================================

Name: lockstep_retire_checker

Overview:
- Sits directly downstream of the dual-core lockstep block and consumes each core's retired-instruction stream: PC, opcode and result.
- Buffers each stream in a small per-core skew FIFO, compares retirements pairwise in order, and counts clean compares.
- Latches the first fault (data mismatch, skew timeout or FIFO overflow) and requests a halt until software clears it.

Parameters:
- DATA_W, 32, result width.
- PC_W, 8, program-counter width.
- OP_W, 7, opcode width.
- DEPTH, 4, entries per skew FIFO; power of two, minimum 2.
- TIMEOUT, 16, consecutive one-sided cycles that raise a timeout fault; range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- check_en  in  1  enables checking; 0 holds the block idle with FIFOs flushed.
- clear_fault  in  1  single-cycle pulse; leaves FAULT.
- retire0  in  1  core0 retired one instruction this cycle.
- pc0  in  PC_W  core0 retired PC.
- opcode0  in  OP_W  core0 retired opcode.
- result0  in  DATA_W  core0 retired result.
- retire1, pc1, opcode1, result1  in  1/PC_W/OP_W/DATA_W  same fields for core1.
- mismatch  out  1  high while in FAULT.
- halt_req  out  1  equals mismatch; drives core stall.
- fault_kind  out  2  0 none, 1 data, 2 timeout, 3 overflow.
- fault_pc  out  PC_W  core0 PC of the faulting entry; for timeout/overflow, PC at the head of the non-empty FIFO.
- fault_result0  out  DATA_W  core0 result of the faulting entry (0 unless kind=1).
- fault_result1  out  DATA_W  core1 result of the faulting entry (0 unless kind=1).
- compare_count  out  16  count of clean compares; saturates at 0xFFFF.

Behaviour:
- Reset: state IDLE, both FIFOs empty, timeout counter 0, and every output 0.
- States and transitions:
  - IDLE -> CHECK when check_en=1.
  - CHECK -> IDLE when check_en=0; flush FIFOs, clear the timeout counter, keep compare_count.
  - CHECK -> FAULT on any fault.
  - FAULT -> CHECK on clear_fault if check_en=1, otherwise FAULT -> IDLE. On this exit, flush FIFOs, zero the counter, set fault_kind and fault_* to 0; compare_count is kept.
- Push rule: in CHECK, retireN=1 writes {pcN, opcodeN, resultN} into FIFO N. Retires are ignored in IDLE and FAULT.
- Pop/compare rule: if both FIFOs are non-empty at the start of cycle N, both heads pop in cycle N and are compared.
  - A pushed entry is poppable no earlier than the next cycle.
  - Compare covers pc, opcode and result; all three must be equal.
- Clean compare: compare_count increments and is visible at N+1.
- Unequal compare: enter FAULT at N+1 with mismatch=1, fault_kind=1, and fault_pc/fault_result0/fault_result1 taken from the popped entries.
- Overflow: a push to a full FIFO with no pop of that FIFO in the same cycle is a fault, kind 3. Push and pop of a full FIFO in the same cycle is legal.
- Timeout counter:
  - Increments each CHECK cycle in which exactly one FIFO is non-empty.
  - Otherwise resets to 0.
  - When the incremented value equals TIMEOUT, fault kind 2 is raised, visible the next cycle.
- Same-cycle fault priority: data > overflow > timeout. Only the first fault is latched; fault fields are frozen during FAULT.
- clear_fault outside FAULT is ignored. clear_fault arriving in the same cycle as a new fault has no effect: the fault wins.
- rst mid-operation returns the block to the reset state in one cycle, including compare_count=0.
- FIFO pointers are log2(DEPTH)+1 bits, so wrap-around is covered; full and empty derive from the pointer MSB.

Decomposition:
- Shared definitions package `lockstep_pkg`:
  - fault-kind constants FK_NONE, FK_DATA, FK_TIMEOUT, FK_OVF;
  - state encoding ST_IDLE, ST_CHECK, ST_FAULT;
  - entry width ENTRY_W = PC_W+OP_W+DATA_W.
- One sub-module, `retire_fifo`: synchronous FIFO, parameters ENTRY_W and DEPTH, ports push/pop/full/empty/head. Instantiated twice.

Test Plan:
- Assert rst for 2 cycles with random inputs -> all outputs 0 and state IDLE; retires while check_en=0 leave compare_count=0.
- check_en=1; both cores retire pc 0x00/0x04/0x08 in the same cycles with equal results -> compare_count=3, mismatch=0.
- Same stream with core1 lagging 2 cycles -> no fault, compare_count=3 two cycles later than the lockstep case.
- Third entry with result0=0x5, result1=0x7 -> one cycle after the compare: mismatch=1, halt_req=1, fault_kind=1, fault_pc=0x08, fault_result0=0x5, fault_result1=0x7, compare_count=2.
- Core0 retires once, core1 is silent -> fault_kind=2 after exactly 16 one-sided cycles. Then clear_fault with check_en=1 -> CHECK, FIFOs empty, fault fields 0.
- DEPTH=4; core0 retires 5 times back-to-back, core1 silent -> fault_kind=3 on the 5th push and fault_pc = first entry's PC. Also: push+pop on a full FIFO in the same cycle -> no fault.

Source files
------------

// File: rtl/lockstep_retire_checker_pkg.sv
// Shared definitions for the lockstep retire checker: FSM states, fault codes
// and default entry geometry.
package lockstep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] FK_NONE    = 2'd0;
    localparam logic [1:0] FK_DATA    = 2'd1;
    localparam logic [1:0] FK_TIMEOUT = 2'd2;
    localparam logic [1:0] FK_OVF     = 2'd3;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_PC_W   = 8;
    localparam int DEF_OP_W   = 7;
    localparam int ENTRY_W    = DEF_PC_W + DEF_OP_W + DEF_DATA_W;

endpackage

// File: rtl/lockstep_retire_checker_if.sv
// Retire streams from both cores plus control inputs and fault/status outputs.
interface lockstep_retire_checker_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8,
    parameter int OP_W   = 7
) ();
    logic              check_en;
    logic              clear_fault;
    logic              retire0;
    logic [PC_W-1:0]   pc0;
    logic [OP_W-1:0]   opcode0;
    logic [DATA_W-1:0] result0;
    logic              retire1;
    logic [PC_W-1:0]   pc1;
    logic [OP_W-1:0]   opcode1;
    logic [DATA_W-1:0] result1;
    logic              mismatch;
    logic              halt_req;
    logic [1:0]        fault_kind;
    logic [PC_W-1:0]   fault_pc;
    logic [DATA_W-1:0] fault_result0;
    logic [DATA_W-1:0] fault_result1;
    logic [15:0]       compare_count;

    modport master (
        output check_en, clear_fault,
        output retire0, pc0, opcode0, result0,
        output retire1, pc1, opcode1, result1,
        input  mismatch, halt_req, fault_kind, fault_pc,
        input  fault_result0, fault_result1, compare_count
    );

    modport slave (
        input  check_en, clear_fault,
        input  retire0, pc0, opcode0, result0,
        input  retire1, pc1, opcode1, result1,
        output mismatch, halt_req, fault_kind, fault_pc,
        output fault_result0, fault_result1, compare_count
    );
endinterface

// File: rtl/lockstep_retire_checker_fifo.sv
// Per-core skew FIFO; extra pointer MSB distinguishes full from empty.
module retire_fifo
    import lockstep_pkg::*;
#(
    parameter int ENTRY_W = lockstep_pkg::ENTRY_W,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [ENTRY_W-1:0] i_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [ENTRY_W-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/lockstep_retire_checker.sv
// Pairwise in-order compare of two cores' retire streams with first-fault
// latching, skew timeout, overflow detection and a saturating clean-compare count.
module lockstep_retire_checker
    import lockstep_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 8,
    parameter int OP_W    = 7,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    lockstep_retire_checker_if.slave bus
);
    localparam int         E_W    = PC_W + OP_W + DATA_W;
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_to_cnt, w_to_nxt;
    logic [15:0]       r_count;
    logic [1:0]        r_fk, w_fk;
    logic [PC_W-1:0]   r_fpc, w_fpc;
    logic [DATA_W-1:0] r_fres0, w_fres0, r_fres1, w_fres1;
    logic              w_flush, w_push0, w_push1, w_pop, w_clean, w_fault;
    logic              w_full0, w_full1, w_empty0, w_empty1, w_one_sided;
    logic [E_W-1:0]    w_head0, w_head1;

    retire_fifo #(.ENTRY_W(E_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst(rst), .i_flush(w_flush), .i_push(w_push0), .i_pop(w_pop),
        .i_data({bus.pc0, bus.opcode0, bus.result0}),
        .o_full(w_full0), .o_empty(w_empty0), .o_head(w_head0)
    );

    retire_fifo #(.ENTRY_W(E_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .i_flush(w_flush), .i_push(w_push1), .i_pop(w_pop),
        .i_data({bus.pc1, bus.opcode1, bus.result1}),
        .o_full(w_full1), .o_empty(w_empty1), .o_head(w_head1)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        w_push0     = 1'b0;
        w_push1     = 1'b0;
        w_pop       = 1'b0;
        w_clean     = 1'b0;
        w_fault     = 1'b0;
        w_fk        = FK_NONE;
        w_fpc       = '0;
        w_fres0     = '0;
        w_fres1     = '0;
        w_to_nxt    = r_to_cnt;
        w_one_sided = w_empty0 ^ w_empty1;
        case (r_state)
            ST_IDLE: begin
                w_flush  = 1'b1;
                w_to_nxt = '0;
                if (bus.check_en) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (!bus.check_en) begin
                    w_flush     = 1'b1;
                    w_to_nxt    = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_pop    = !w_empty0 && !w_empty1;
                    // A full FIFO only accepts a write when its head leaves the same cycle.
                    w_push0  = bus.retire0 && (!w_full0 || w_pop);
                    w_push1  = bus.retire1 && (!w_full1 || w_pop);
                    w_to_nxt = w_one_sided ? r_to_cnt + 8'd1 : 8'd0;
                    if (w_pop && (w_head0 != w_head1)) begin
                        w_fault = 1'b1;
                        w_fk    = FK_DATA;
                        w_fpc   = w_head0[E_W-1 -: PC_W];
                        w_fres0 = w_head0[DATA_W-1:0];
                        w_fres1 = w_head1[DATA_W-1:0];
                    end else if (bus.retire0 && w_full0 && !w_pop) begin
                        w_fault = 1'b1;
                        w_fk    = FK_OVF;
                        w_fpc   = w_head0[E_W-1 -: PC_W];
                    end else if (bus.retire1 && w_full1 && !w_pop) begin
                        w_fault = 1'b1;
                        w_fk    = FK_OVF;
                        w_fpc   = w_head1[E_W-1 -: PC_W];
                    end else if (w_one_sided && (w_to_nxt == TO_LIM)) begin
                        w_fault = 1'b1;
                        w_fk    = FK_TIMEOUT;
                        w_fpc   = w_empty0 ? w_head1[E_W-1 -: PC_W] : w_head0[E_W-1 -: PC_W];
                    end else begin
                        w_clean = w_pop;
                    end
                    if (w_fault) w_state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (bus.clear_fault) begin
                    w_flush     = 1'b1;
                    w_to_nxt    = '0;
                    w_state_nxt = bus.check_en ? ST_CHECK : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_count  <= '0;
        end else begin
            r_to_cnt <= w_to_nxt;
            if (w_clean && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ((r_state == ST_FAULT) && bus.clear_fault)) begin
            r_fk    <= FK_NONE;
            r_fpc   <= '0;
            r_fres0 <= '0;
            r_fres1 <= '0;
        end else if (w_fault) begin
            r_fk    <= w_fk;
            r_fpc   <= w_fpc;
            r_fres0 <= w_fres0;
            r_fres1 <= w_fres1;
        end
    end

    assign bus.mismatch      = (r_state == ST_FAULT);
    assign bus.halt_req      = (r_state == ST_FAULT);
    assign bus.fault_kind    = r_fk;
    assign bus.fault_pc      = r_fpc;
    assign bus.fault_result0 = r_fres0;
    assign bus.fault_result1 = r_fres1;
    assign bus.compare_count = r_count;
endmodule

// File: tb/tb_lockstep_retire_checker.sv
// Directed bench for lockstep_retire_checker: reset, lockstep, skew, data
// mismatch, timeout with clear, overflow and full-FIFO push+pop.
module tb_lockstep_retire_checker;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    lockstep_retire_checker_if #(.DATA_W(32), .PC_W(8), .OP_W(7)) bus ();

    lockstep_retire_checker #(
        .DATA_W(32), .PC_W(8), .OP_W(7), .DEPTH(4), .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.retire0     = 1'b0;
        bus.retire1     = 1'b0;
        bus.clear_fault = 1'b0;
    endtask

    task automatic core0(input logic [7:0] pc, input logic [31:0] res);
        bus.retire0 = 1'b1;
        bus.pc0     = pc;
        bus.opcode0 = 7'h13;
        bus.result0 = res;
    endtask

    task automatic core1(input logic [7:0] pc, input logic [31:0] res);
        bus.retire1 = 1'b1;
        bus.pc1     = pc;
        bus.opcode1 = 7'h13;
        bus.result1 = res;
    endtask

    task automatic do_reset();
        quiet();
        bus.check_en = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic enable();
        bus.check_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.check_en    = 1'($urandom);
            bus.clear_fault = 1'($urandom);
            bus.retire0     = 1'($urandom);
            bus.retire1     = 1'($urandom);
            bus.pc0         = 8'($urandom);
            bus.pc1         = 8'($urandom);
            bus.opcode0     = 7'($urandom);
            bus.opcode1     = 7'($urandom);
            bus.result0     = $urandom;
            bus.result1     = $urandom;
            tick();
        end
        n_checks++;
        if ({bus.mismatch, bus.halt_req, bus.fault_kind} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {bus.mismatch, bus.halt_req, bus.fault_kind});
        end
        n_checks++;
        if ({bus.fault_pc, bus.fault_result0, bus.fault_result1, bus.compare_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: pc %h r0 %h r1 %h cnt %h expected all 0",
                     bus.fault_pc, bus.fault_result0, bus.fault_result1, bus.compare_count);
        end
        rst = 1'b0;
        quiet();
        bus.check_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            core0(8'(4 * i), 32'h10 + i);
            core1(8'(4 * i), 32'h10 + i);
            tick();
        end
        quiet();
        tick();
        tick();
        n_checks++;
        if (bus.compare_count !== 16'd0 || bus.mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_retire: cnt %0d mismatch %b expected 0 0", bus.compare_count, bus.mismatch);
        end
    endtask

    task automatic test_lockstep();
        do_reset();
        enable();
        for (int i = 0; i < 3; i++) begin
            core0(8'(4 * i), 32'h100 + i);
            core1(8'(4 * i), 32'h100 + i);
            tick();
        end
        quiet();
        n_checks++;
        if (bus.compare_count !== 16'd2) begin
            n_fail++;
            $display("FAIL lockstep_cnt2: got %0d expected 2", bus.compare_count);
        end
        tick();
        n_checks++;
        if (bus.compare_count !== 16'd3 || bus.mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL lockstep_cnt3: cnt %0d mismatch %b expected 3 0", bus.compare_count, bus.mismatch);
        end
    endtask

    task automatic test_skew();
        do_reset();
        enable();
        for (int c = 0; c < 5; c++) begin
            quiet();
            if (c < 3) core0(8'(4 * c), 32'h200 + c);
            if (c >= 2) core1(8'(4 * (c - 2)), 32'h200 + c - 2);
            tick();
        end
        quiet();
        n_checks++;
        if (bus.compare_count !== 16'd2) begin
            n_fail++;
            $display("FAIL skew_cnt2: got %0d expected 2", bus.compare_count);
        end
        tick();
        n_checks++;
        if (bus.compare_count !== 16'd3 || bus.mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL skew_cnt3: cnt %0d mismatch %b expected 3 0", bus.compare_count, bus.mismatch);
        end
    endtask

    task automatic test_data_mismatch();
        do_reset();
        enable();
        core0(8'h00, 32'h1); core1(8'h00, 32'h1); tick();
        core0(8'h04, 32'h2); core1(8'h04, 32'h2); tick();
        core0(8'h08, 32'h5); core1(8'h08, 32'h7); tick();
        quiet();
        n_checks++;
        if (bus.mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL data_early: mismatch %b expected 0", bus.mismatch);
        end
        tick();
        n_checks++;
        if (bus.mismatch !== 1'b1 || bus.halt_req !== 1'b1 || bus.fault_kind !== 2'd1) begin
            n_fail++;
            $display("FAIL data_flags: mm %b halt %b kind %0d expected 1 1 1",
                     bus.mismatch, bus.halt_req, bus.fault_kind);
        end
        n_checks++;
        if (bus.fault_pc !== 8'h08 || bus.fault_result0 !== 32'h5 || bus.fault_result1 !== 32'h7) begin
            n_fail++;
            $display("FAIL data_fields: pc %h r0 %h r1 %h expected 08 5 7",
                     bus.fault_pc, bus.fault_result0, bus.fault_result1);
        end
        n_checks++;
        if (bus.compare_count !== 16'd2) begin
            n_fail++;
            $display("FAIL data_cnt: got %0d expected 2", bus.compare_count);
        end
        core0(8'h0C, 32'h9); core1(8'h0C, 32'h9);
        tick();
        tick();
        quiet();
        n_checks++;
        if (bus.fault_pc !== 8'h08 || bus.compare_count !== 16'd2 || bus.fault_kind !== 2'd1) begin
            n_fail++;
            $display("FAIL data_frozen: pc %h cnt %0d kind %0d expected 08 2 1",
                     bus.fault_pc, bus.compare_count, bus.fault_kind);
        end
    endtask

    task automatic test_timeout_clear();
        do_reset();
        enable();
        core0(8'h10, 32'hAA);
        tick();
        quiet();
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if (bus.fault_kind !== 2'd0 || bus.mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: kind %0d mm %b expected 0 0", bus.fault_kind, bus.mismatch);
        end
        tick();
        n_checks++;
        if (bus.fault_kind !== 2'd2 || bus.mismatch !== 1'b1 || bus.fault_pc !== 8'h10) begin
            n_fail++;
            $display("FAIL timeout_fault: kind %0d mm %b pc %h expected 2 1 10",
                     bus.fault_kind, bus.mismatch, bus.fault_pc);
        end
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        n_checks++;
        if (bus.mismatch !== 1'b0 || bus.fault_kind !== 2'd0 || bus.fault_pc !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_fields: mm %b kind %0d pc %h expected 0 0 00",
                     bus.mismatch, bus.fault_kind, bus.fault_pc);
        end
        core0(8'h20, 32'hBB); core1(8'h20, 32'hBB);
        tick();
        quiet();
        tick();
        n_checks++;
        if (bus.compare_count !== 16'd1 || bus.mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flushed: cnt %0d mm %b expected 1 0", bus.compare_count, bus.mismatch);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        enable();
        for (int i = 0; i < 4; i++) begin
            core0(8'(8'h40 + 4 * i), 32'h300 + i);
            tick();
        end
        n_checks++;
        if (bus.mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_early: mm %b expected 0", bus.mismatch);
        end
        core0(8'h50, 32'h304);
        tick();
        quiet();
        n_checks++;
        if (bus.fault_kind !== 2'd3 || bus.mismatch !== 1'b1 || bus.fault_pc !== 8'h40) begin
            n_fail++;
            $display("FAIL ovf_fault: kind %0d mm %b pc %h expected 3 1 40",
                     bus.fault_kind, bus.mismatch, bus.fault_pc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable();
        for (int c = 0; c < 9; c++) begin
            quiet();
            if (c < 5) core0(8'(8'h60 + 4 * c), 32'h400 + c);
            if (c >= 3 && c < 8) core1(8'(8'h60 + 4 * (c - 3)), 32'h400 + c - 3);
            tick();
        end
        quiet();
        n_checks++;
        if (bus.mismatch !== 1'b0 || bus.fault_kind !== 2'd0) begin
            n_fail++;
            $display("FAIL full_pushpop: mm %b kind %0d expected 0 0", bus.mismatch, bus.fault_kind);
        end
        n_checks++;
        if (bus.compare_count !== 16'd5) begin
            n_fail++;
            $display("FAIL full_cnt: got %0d expected 5", bus.compare_count);
        end
    endtask

    task automatic test_rst_mid();
        bus.clear_fault = 1'b1;
        tick();
        bus.clear_fault = 1'b0;
        n_checks++;
        if (bus.compare_count !== 16'd5 || bus.mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_outside_fault: cnt %0d mm %b expected 5 0", bus.compare_count, bus.mismatch);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.compare_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_cnt: got %0d expected 0", bus.compare_count);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.check_en    = 1'b0;
        bus.clear_fault = 1'b0;
        bus.retire0     = 1'b0;
        bus.retire1     = 1'b0;
        bus.pc0         = '0;
        bus.pc1         = '0;
        bus.opcode0     = '0;
        bus.opcode1     = '0;
        bus.result0     = '0;
        bus.result1     = '0;
        test_reset();
        test_lockstep();
        test_skew();
        test_data_mismatch();
        test_timeout_clear();
        test_overflow();
        test_back_to_back();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
